reg_bank: RTL and testbench
===========================

# reg_bank

Parametrised register bank that succeeds the single 8-bit enable-gated register. It holds DEPTH independently addressable WIDTH-bit registers. A registered read port returns data one cycle after the request, with a valid strobe. It sits behind the same clocked tx_master-style driver and monitor, with an address and a read/write select added to the existing data/enable/outa signal set.

## Interface
- WIDTH, 8, data width of each register and of data/outa
- DEPTH, 4, number of registers; any value ≥ 2 is legal and need not be a power of 2
- RESET_VAL, 0, WIDTH-bit value loaded into every register on reset and on clear
- AW, $clog2(DEPTH), address width (derived; not overridden)

- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  request qualifier; nothing happens when low
- wr  input  1  1 = write, 0 = read (sampled only when enable=1)
- addr  input  AW  register index
- data  input  WIDTH  write data
- clear  input  1  synchronous clear of all registers
- outa  output  WIDTH  read data, registered
- out_valid  output  1  one-cycle strobe, outa updated this cycle
- addr_err  output  1  one-cycle strobe, last request addressed index ≥ DEPTH

## Operation
- Reset (reset_n=0, asynchronous, any time):
  - all registers = RESET_VAL
  - outa = 0, out_valid = 0, addr_err = 0
  - a request in flight is discarded; no strobe after reset release
- Write: enable=1, wr=1, addr<DEPTH at edge N → reg[addr]=data after edge N.
- Read: enable=1, wr=0, addr<DEPTH at edge N → after edge N:
  - outa = reg[addr] as held before edge N
  - out_valid = 1 for exactly one cycle
- outa holds its last read value until the next valid read. It is not cleared by clear.
- Out-of-range request (addr ≥ DEPTH), read or write:
  - no register changes
  - outa is unchanged
  - out_valid = 0
  - addr_err = 1 for one cycle
- clear=1 at an edge → all registers = RESET_VAL.
  - clear beats a simultaneous write: the write is dropped.
  - A simultaneous read still completes and returns the pre-clear value with out_valid=1.
- Back-to-back requests are accepted every cycle; there is no stall and no backpressure.
- Read of an address written in the immediately preceding cycle returns the new value.
- No state machine beyond the per-register storage and the output stage. The output stage is either IDLE or in a one-cycle strobe (RESP), returning to IDLE unless a new request arrives.

## Timing
- Write latency: 0 cycles to storage; visible to a read issued at the next edge.
- Read latency: 1 cycle from the sampling edge to outa/out_valid.
- Throughput: 1 request per cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Inputs are sampled at the rising edge. The bench drives with a 1 ns output skew and samples with a 1 ns input skew, as the existing clocking block does.

## Configuration
- REG_BANK_PARITY_EN, when defined:
  - each register stores one extra even-parity bit, computed on write and on clear/reset
  - a read recomputes parity over the stored data
  - on mismatch, output parity_err (1 bit, registered) pulses with out_valid; reset value 0
  - a compiler-only test hook, force_parity_flip (1-bit input), inverts the stored parity bit on a write
- When not defined: no parity storage, no parity_err port, no force_parity_flip port; behaviour otherwise identical.

## Test plan
All scenarios use WIDTH=8, DEPTH=4 unless noted.
- Reset check:
  - assert reset_n=0 mid-stream after writing 0x5A to reg 2
  - → outa=0x00, out_valid=0, addr_err=0 immediately
  - → after release, read of reg 2 returns 0x00 (RESET_VAL=0)
- Write/read all:
  - write 0x11, 0x22, 0x33, 0x44 to addr 0..3
  - read 3,2,1,0 back-to-back
  - → outa = 0x44, 0x33, 0x22, 0x11 on consecutive cycles, out_valid high for 4 consecutive cycles
- Read-after-write:
  - write 0xA5 to addr 1 at edge N, read addr 1 at edge N+1
  - → outa=0xA5, out_valid=1 after edge N+1
- Clear vs write:
  - clear=1 with write 0xFF to addr 0 and, with DEPTH=3 build, a read of addr 2 holding 0x77 on the same edge
  - → read returns 0x77 with out_valid=1
  - → subsequent reads of addr 0 and 2 return RESET_VAL
- Out of range (DEPTH=3):
  - write 0x99 to addr 3
  - → addr_err=1 one cycle, no register changes
  - read addr 3 → addr_err=1, out_valid=0, outa keeps previous value
- Parity (REG_BANK_PARITY_EN):
  - write 0x0F with force_parity_flip=1, then read
  - → outa=0x0F, out_valid=1, parity_err=1
  - a normal write/read of 0x0F → parity_err=0

Source files
------------

// File: rtl/reg_bank.sv
// reg_bank: DEPTH independently addressable WIDTH-bit registers with a
// registered read port (one-cycle latency, out_valid strobe) and an
// out-of-range strobe (addr_err).
//
// Optional feature macro: REG_BANK_PARITY_EN
//   When defined, every register carries an even-parity bit. A read
//   recomputes parity and pulses parity_err together with out_valid on a
//   mismatch. force_parity_flip inverts the stored parity bit on a write.

module reg_bank #(
   parameter int unsigned         WIDTH     = 8,
   parameter int unsigned         DEPTH     = 4,
   parameter logic [WIDTH-1:0]    RESET_VAL = '0,
   localparam int unsigned        AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             wr,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] data,
   input  logic             clear,
   output logic [WIDTH-1:0] outa,
   output logic             out_valid,
   output logic             addr_err
`ifdef REG_BANK_PARITY_EN
  ,input  logic             force_parity_flip,
   output logic             parity_err
`endif
);

   // One extra bit so addr == DEPTH compares correctly for power-of-2 depths.
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   typedef enum logic [0:0] {
      StIdle,
      StResp
   } out_state_e;

   logic                 in_range;
   logic                 req_rd;
   logic                 req_wr;
   logic                 req_err;

   logic [WIDTH-1:0]     regs_q [DEPTH];
   logic [WIDTH-1:0]     regs_d [DEPTH];
   logic [WIDTH-1:0]     rd_data;

   logic [WIDTH-1:0]     outa_q, outa_d;
   logic                 addr_err_q, addr_err_d;
   out_state_e           state_q, state_d;

`ifdef REG_BANK_PARITY_EN
   logic                 par_q [DEPTH];
   logic                 par_d [DEPTH];
   logic                 rd_par;
   logic                 parity_err_q, parity_err_d;
`endif

   // Request decode: classify the sampled request as read, write or error.
   always_comb begin
      in_range = ({1'b0, addr} < DEPTH_W);
      req_rd   = enable && !wr && in_range;
      req_wr   = enable &&  wr && in_range;
      req_err  = enable && !in_range;
   end

   // Read mux over the storage as held before the current edge.
   always_comb begin
      rd_data = RESET_VAL;
      if (in_range) begin
         rd_data = regs_q[addr];
      end
   end

   // Storage next state: clear wins over a simultaneous write.
   always_comb begin
      regs_d = regs_q;
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = RESET_VAL;
         end
      end else if (req_wr) begin
         regs_d[addr] = data;
      end
   end

   // Storage registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= RESET_VAL;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

`ifdef REG_BANK_PARITY_EN
   // Parity next state follows the storage, with the test hook applied on write.
   always_comb begin
      par_d = par_q;
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            par_d[i] = ^RESET_VAL;
         end
      end else if (req_wr) begin
         par_d[addr] = (^data) ^ force_parity_flip;
      end
   end

   // Stored parity bits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            par_q[i] <= ^RESET_VAL;
         end
      end else begin
         par_q <= par_d;
      end
   end

   // Stored parity of the addressed entry; only consulted on in-range reads.
   always_comb begin
      rd_par = ^RESET_VAL;
      if (in_range) begin
         rd_par = par_q[addr];
      end
   end
`endif

   // Output stage next state: outa holds unless a valid read lands.
   always_comb begin
      outa_d     = outa_q;
      addr_err_d = req_err;
      if (req_rd) begin
         outa_d = rd_data;
      end
`ifdef REG_BANK_PARITY_EN
      parity_err_d = req_rd && ((^rd_data) != rd_par);
`endif
   end

   // Output stage FSM: next-state logic, a strobe only follows an accepted read.
   always_comb begin
      state_d = StIdle;
      if (req_rd) begin
         state_d = StResp;
      end
   end

   // Output stage FSM: state and output data registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         outa_q     <= '0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         outa_q     <= outa_d;
         addr_err_q <= addr_err_d;
      end
   end

`ifdef REG_BANK_PARITY_EN
   // Parity error flag, registered alongside out_valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end
`endif

   // Output FSM: outputs decoded from registered state only.
   always_comb begin
      out_valid = (state_q == StResp);
      outa      = outa_q;
      addr_err  = addr_err_q;
`ifdef REG_BANK_PARITY_EN
      parity_err = parity_err_q;
`endif
   end

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: a DEPTH=4 and a DEPTH=3 instance share one stimulus
// stream; a behavioural model per instance pushes expected responses into a
// scoreboard queue at drive time, and they are popped after each edge.

module tb_reg_bank;

   logic       clk;
   logic       reset_n;
   logic       enable;
   logic       wr;
   logic [1:0] addr;
   logic [7:0] data;
   logic       clear;

   logic [7:0] outa4, outa3;
   logic       valid4, valid3;
   logic       err4, err3;
`ifdef REG_BANK_PARITY_EN
   logic       force_parity_flip;
   logic       perr4, perr3;
`endif

   reg_bank #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut4 (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .wr        (wr),
      .addr      (addr),
      .data      (data),
      .clear     (clear),
      .outa      (outa4),
      .out_valid (valid4),
      .addr_err  (err4)
`ifdef REG_BANK_PARITY_EN
     ,.force_parity_flip (force_parity_flip),
      .parity_err        (perr4)
`endif
   );

   reg_bank #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut3 (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .wr        (wr),
      .addr      (addr),
      .data      (data),
      .clear     (clear),
      .outa      (outa3),
      .out_valid (valid3),
      .addr_err  (err3)
`ifdef REG_BANK_PARITY_EN
     ,.force_parity_flip (force_parity_flip),
      .parity_err        (perr3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic       e;
      logic [7:0] d;
      logic       p;
   } exp_t;

   exp_t       sb4[$];
   exp_t       sb3[$];
   logic [7:0] mem  [2][4];
   logic       pfl  [2][4];
   logic [7:0] last [2];
   int         dep  [2];
   int         n_chk;
   int         n_pass;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         last[k] = 8'h00;
         for (int i = 0; i < 4; i++) begin
            mem[k][i] = 8'h00;
            pfl[k][i] = 1'b0;
         end
      end
      sb4.delete();
      sb3.delete();
   endtask

   // Apply one request (1 ns after an edge) and queue each instance's response.
   task automatic drive(input logic en, input logic w, input logic [1:0] a,
                        input logic [7:0] d, input logic clr, input logic flip);
      exp_t x;
      logic inr;
      enable = en;
      wr     = w;
      addr   = a;
      data   = d;
      clear  = clr;
`ifdef REG_BANK_PARITY_EN
      force_parity_flip = flip;
`endif
      for (int k = 0; k < 2; k++) begin
         inr = (int'(a) < dep[k]);
         x.v = en && !w && inr;
         x.e = en && !inr;
         if (x.v) last[k] = mem[k][a];
         x.d = last[k];
         x.p = x.v && pfl[k][a];
         if (clr) begin
            for (int i = 0; i < 4; i++) begin
               mem[k][i] = 8'h00;
               pfl[k][i] = 1'b0;
            end
         end else if (en && w && inr) begin
            mem[k][a] = d;
            pfl[k][a] = flip;
         end
         if (k == 0) sb4.push_back(x);
         else        sb3.push_back(x);
      end
   endtask

   // Advance one edge, then pop and compare the response of both instances.
   task automatic tick(input string tag);
      exp_t x;
      @(posedge clk);
      #1;
      if (sb4.size() == 0 || sb3.size() == 0) begin
         chk({tag, "/scoreboard_empty"}, 8'h01, 8'h00);
      end else begin
         x = sb4.pop_front();
         chk({tag, "/d4 outa"},  outa4,        x.d);
         chk({tag, "/d4 valid"}, {7'd0, valid4}, {7'd0, x.v});
         chk({tag, "/d4 err"},   {7'd0, err4},   {7'd0, x.e});
`ifdef REG_BANK_PARITY_EN
         chk({tag, "/d4 perr"},  {7'd0, perr4},  {7'd0, x.p});
`endif
         x = sb3.pop_front();
         chk({tag, "/d3 outa"},  outa3,        x.d);
         chk({tag, "/d3 valid"}, {7'd0, valid3}, {7'd0, x.v});
         chk({tag, "/d3 err"},   {7'd0, err3},   {7'd0, x.e});
`ifdef REG_BANK_PARITY_EN
         chk({tag, "/d3 perr"},  {7'd0, perr3},  {7'd0, x.p});
`endif
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "/d4 outa"},  outa4,          8'h00);
      chk({tag, "/d4 valid"}, {7'd0, valid4}, 8'h00);
      chk({tag, "/d4 err"},   {7'd0, err4},   8'h00);
      chk({tag, "/d3 outa"},  outa3,          8'h00);
      chk({tag, "/d3 valid"}, {7'd0, valid3}, 8'h00);
      chk({tag, "/d3 err"},   {7'd0, err3},   8'h00);
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      dep[0] = 4;
      dep[1] = 3;
      reset_n = 1'b0;
      enable  = 1'b0;
      wr      = 1'b0;
      addr    = 2'd0;
      data    = 8'h00;
      clear   = 1'b0;
`ifdef REG_BANK_PARITY_EN
      force_parity_flip = 1'b0;
`endif
      model_reset();
      #1;
      check_reset_outputs("por");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Reset mid-stream with a read in flight.
      drive(1, 1, 2'd2, 8'h5A, 0, 0); tick("w5a");
      drive(1, 0, 2'd2, 8'h00, 0, 0); tick("r5a");
      drive(1, 0, 2'd2, 8'h00, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      drive(0, 0, 2'd0, 8'h00, 0, 0); tick("post_rst_idle");
      drive(1, 0, 2'd2, 8'h00, 0, 0); tick("post_rst_rd2");

      // Write all, read back-to-back in reverse.
      drive(1, 1, 2'd0, 8'h11, 0, 0); tick("w0");
      drive(1, 1, 2'd1, 8'h22, 0, 0); tick("w1");
      drive(1, 1, 2'd2, 8'h33, 0, 0); tick("w2");
      drive(1, 1, 2'd3, 8'h44, 0, 0); tick("w3");
      drive(1, 0, 2'd3, 8'h00, 0, 0); tick("r3");
      drive(1, 0, 2'd2, 8'h00, 0, 0); tick("r2");
      drive(1, 0, 2'd1, 8'h00, 0, 0); tick("r1");
      drive(1, 0, 2'd0, 8'h00, 0, 0); tick("r0");

      // Read immediately after write.
      drive(1, 1, 2'd1, 8'hA5, 0, 0); tick("raw_w");
      drive(1, 0, 2'd1, 8'h00, 0, 0); tick("raw_r");

      // Clear against a read and against a write.
      drive(1, 1, 2'd2, 8'h77, 0, 0); tick("clr_pre_w2");
      drive(1, 1, 2'd0, 8'h55, 0, 0); tick("clr_pre_w0");
      drive(1, 0, 2'd2, 8'h00, 1, 0); tick("clr_rd2");
      drive(1, 1, 2'd0, 8'h66, 0, 0); tick("clr_rewrite0");
      drive(1, 1, 2'd0, 8'hFF, 1, 0); tick("clr_wr0");
      drive(1, 0, 2'd0, 8'h00, 0, 0); tick("clr_chk0");
      drive(1, 0, 2'd2, 8'h00, 0, 0); tick("clr_chk2");
      drive(1, 0, 2'd1, 8'h00, 0, 0); tick("clr_chk1");

      // Out-of-range write and read (index 3 is invalid only for DEPTH=3).
      drive(1, 1, 2'd0, 8'h01, 0, 0); tick("oor_w0");
      drive(1, 1, 2'd1, 8'h02, 0, 0); tick("oor_w1");
      drive(1, 1, 2'd2, 8'h03, 0, 0); tick("oor_w2");
      drive(1, 0, 2'd2, 8'h00, 0, 0); tick("oor_r2_pre");
      drive(1, 1, 2'd3, 8'h99, 0, 0); tick("oor_w3");
      drive(1, 0, 2'd3, 8'h00, 0, 0); tick("oor_r3");
      drive(0, 0, 2'd0, 8'h00, 0, 0); tick("oor_idle");
      drive(1, 0, 2'd0, 8'h00, 0, 0); tick("oor_r0");
      drive(1, 0, 2'd1, 8'h00, 0, 0); tick("oor_r1");
      drive(1, 0, 2'd2, 8'h00, 0, 0); tick("oor_r2");

      // Disabled requests do nothing.
      drive(0, 1, 2'd0, 8'hEE, 0, 0); tick("dis_w0");
      drive(0, 0, 2'd3, 8'h00, 0, 0); tick("dis_r3");
      drive(1, 0, 2'd0, 8'h00, 0, 0); tick("dis_chk0");

`ifdef REG_BANK_PARITY_EN
      // Corrupted parity is reported; a clean rewrite reports none.
      drive(1, 1, 2'd1, 8'h0F, 0, 1); tick("par_wflip");
      drive(1, 0, 2'd1, 8'h00, 0, 0); tick("par_rbad");
      drive(1, 1, 2'd1, 8'h0F, 0, 0); tick("par_wok");
      drive(1, 0, 2'd1, 8'h00, 0, 0); tick("par_rok");
`endif

      drive(0, 0, 2'd0, 8'h00, 0, 0); tick("final_idle");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
